// File: rtl/cia_bus_initiator_if.sv
// ---------------------------------------------------------------------------
// cia_bus_initiator_if
//
// Groups the host request/response handshake and the CIA peripheral bus
// used by cia_bus_initiator.
//
// Signals
//   phi2_p, phi2_n   single-clk strobes at the Phi2 rising / falling edges
//   req_valid/ready  host request handshake (transfer when both high)
//   req_rw           1 = read, 0 = write
//   req_rs           register select of the request
//   req_wdata        write data of the request
//   rsp_valid        one-clk completion pulse (reads and writes)
//   rsp_rdata        read data of the last completed read
//   rsp_auto         response came from an automatic interrupt-status read
//   cs_n, rw, rs     peripheral chip select, direction, register select
//   db_out           data towards the peripheral (its db_in)
//   db_in            data from the peripheral (its db_out)
//   irq_n            peripheral interrupt request, active-low
//   busy             initiator is not idle
//
// Modports
//   master  the initiator side
//   slave   the host/peripheral side
// ---------------------------------------------------------------------------
interface cia_bus_initiator_if;
    logic       phi2_p;
    logic       phi2_n;

    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [3:0] req_rs;
    logic [7:0] req_wdata;

    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_auto;

    logic       cs_n;
    logic       rw;
    logic [3:0] rs;
    logic [7:0] db_out;
    logic [7:0] db_in;
    logic       irq_n;

    logic       busy;

    modport master (
        input  phi2_p, phi2_n,
        input  req_valid, req_rw, req_rs, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_auto,
        output cs_n, rw, rs, db_out,
        input  db_in, irq_n,
        output busy
    );

    modport slave (
        output phi2_p, phi2_n,
        output req_valid, req_rw, req_rs, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_auto,
        input  cs_n, rw, rs, db_out,
        output db_in, irq_n,
        input  busy
    );
endinterface

// File: rtl/cia_bus_initiator.sv
// ---------------------------------------------------------------------------
// cia_bus_initiator
//
// Turns host register requests into single CIA bus cycles aligned to Phi2.
// A request is accepted in IDLE, waits for the next Phi2 rising strobe,
// drives the bus until the Phi2 falling strobe, then spends one clk in
// CAPTURE where read data is sampled. Every completed access produces a
// one-clk rsp_valid pulse.
//
// Optional feature (macro CIA_IRQ_AUTOACK_EN): a low irq_n triggers an
// automatic read of the interrupt control register (register select ICR_RS),
// reported with rsp_auto = 1. Without the macro irq_n is ignored and
// rsp_auto is constant 0.
//
// Parameters
//   ICR_RS  register select used for automatic interrupt-status reads
//
// Ports
//   clk  system clock, rising edge
//   res  synchronous active-high reset
//   bus  cia_bus_initiator_if.master (handshake, response, CIA bus, busy)
// ---------------------------------------------------------------------------
module cia_bus_initiator #(
    parameter logic [3:0] ICR_RS = 4'hD
) (
    input  logic                   clk,
    input  logic                   res,
    cia_bus_initiator_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_P  = 2'd1,
        ACCESS  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t     state, state_d;

    // Latched request, held from acceptance until the bus cycle starts
    logic       lat_rw, lat_rw_d;
    logic [3:0] lat_rs, lat_rs_d;
    logic [7:0] lat_wdata, lat_wdata_d;

    // Registered bus and response outputs
    logic       cs_n_q, cs_n_d;
    logic       rw_q, rw_d;
    logic [3:0] rs_q, rs_d;
    logic [7:0] db_out_q, db_out_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;

    logic       phi_p;
    logic       phi_n;
    logic       auto_start;

    // A coincident falling strobe is discarded so the rising edge wins
    assign phi_p = bus.phi2_p;
    assign phi_n = bus.phi2_n & ~bus.phi2_p;

`ifdef CIA_IRQ_AUTOACK_EN
    logic irq_s;
    logic arm;
    logic lat_auto, lat_auto_d;
    logic rsp_auto_q, rsp_auto_d;

    // arm re-enables only after irq_s has been seen high, so a level that
    // stays low after an auto-read does not retrigger it
    always_ff @(posedge clk) begin
        if (res) begin
            irq_s <= 1'b1;
            arm   <= 1'b0;
        end else begin
            irq_s <= bus.irq_n;
            if (auto_start)
                arm <= 1'b0;
            else if (irq_s)
                arm <= 1'b1;
        end
    end

    assign auto_start   = (state == IDLE) && !irq_s && arm;
    assign bus.rsp_auto = rsp_auto_q;
`else
    assign auto_start   = 1'b0;
    assign bus.rsp_auto = 1'b0;
`endif

    // Gating with res keeps the handshake closed while reset is held
    assign bus.req_ready = (state == IDLE) && !res && !auto_start;
    assign bus.busy      = (state != IDLE) && !res;

    assign bus.cs_n      = cs_n_q;
    assign bus.rw        = rw_q;
    assign bus.rs        = rs_q;
    assign bus.db_out    = db_out_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    always_comb begin
        state_d     = state;
        lat_rw_d    = lat_rw;
        lat_rs_d    = lat_rs;
        lat_wdata_d = lat_wdata;
        cs_n_d      = cs_n_q;
        rw_d        = rw_q;
        rs_d        = rs_q;
        db_out_d    = db_out_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef CIA_IRQ_AUTOACK_EN
        lat_auto_d  = lat_auto;
        rsp_auto_d  = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (auto_start) begin
                    lat_rw_d    = 1'b1;
                    lat_rs_d    = ICR_RS;
                    lat_wdata_d = 8'h00;
`ifdef CIA_IRQ_AUTOACK_EN
                    lat_auto_d  = 1'b1;
`endif
                    state_d     = WAIT_P;
                end else if (bus.req_valid) begin
                    lat_rw_d    = bus.req_rw;
                    lat_rs_d    = bus.req_rs;
                    lat_wdata_d = bus.req_wdata;
`ifdef CIA_IRQ_AUTOACK_EN
                    lat_auto_d  = 1'b0;
`endif
                    state_d     = WAIT_P;
                end
            end

            // The acceptance clk is spent in IDLE, so a strobe coinciding
            // with the handshake is never seen here
            WAIT_P: begin
                if (phi_p) begin
                    cs_n_d   = 1'b0;
                    rw_d     = lat_rw;
                    rs_d     = lat_rs;
                    db_out_d = lat_wdata;
                    state_d  = ACCESS;
                end
            end

            ACCESS: begin
                if (phi_n) begin
                    cs_n_d  = 1'b1;
                    rw_d    = 1'b1;
                    state_d = CAPTURE;
                end
            end

            CAPTURE: begin
                rsp_valid_d = 1'b1;
                if (lat_rw)
                    rsp_rdata_d = bus.db_in;
`ifdef CIA_IRQ_AUTOACK_EN
                rsp_auto_d  = lat_auto;
`endif
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state       <= IDLE;
            cs_n_q      <= 1'b1;
            rw_q        <= 1'b1;
            rs_q        <= 4'h0;
            db_out_q    <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            state       <= state_d;
            cs_n_q      <= cs_n_d;
            rw_q        <= rw_d;
            rs_q        <= rs_d;
            db_out_q    <= db_out_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Request latch is always loaded in IDLE before it is used
    always_ff @(posedge clk) begin
        lat_rw    <= lat_rw_d;
        lat_rs    <= lat_rs_d;
        lat_wdata <= lat_wdata_d;
    end

`ifdef CIA_IRQ_AUTOACK_EN
    always_ff @(posedge clk) begin
        lat_auto <= lat_auto_d;
        if (res)
            rsp_auto_q <= 1'b0;
        else
            rsp_auto_q <= rsp_auto_d;
    end
`endif

endmodule

// File: tb/tb_cia_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_cia_bus_initiator
//
// Directed bench for cia_bus_initiator. Phi2 strobes are driven explicitly
// per clk so every bus window is placed exactly; outputs are sampled 1 time
// unit after the rising clk edge.
// ---------------------------------------------------------------------------
module tb_cia_bus_initiator;

    logic clk;
    logic res;
    int   checks   = 0;
    int   failures = 0;

    cia_bus_initiator_if bus();

    cia_bus_initiator #(.ICR_RS(4'hD)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clk with the given Phi2 strobes; returns just after the edge
    task automatic cyc(input logic p, input logic n);
        bus.phi2_p = p;
        bus.phi2_n = n;
        @(posedge clk);
        #1;
        bus.phi2_p = 1'b0;
        bus.phi2_n = 1'b0;
    endtask

    initial begin
        res           = 1'b1;
        bus.phi2_p    = 1'b0;
        bus.phi2_n    = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_rw    = 1'b0;
        bus.req_rs    = 4'h0;
        bus.req_wdata = 8'h00;
        bus.db_in     = 8'h00;
        bus.irq_n     = 1'b1;

        // Reset state
        cyc(0, 0);
        cyc(0, 0);
        chk("rst_cs_n",      bus.cs_n,      8'h01);
        chk("rst_rw",        bus.rw,        8'h01);
        chk("rst_rs",        bus.rs,        8'h00);
        chk("rst_db_out",    bus.db_out,    8'h00);
        chk("rst_rsp_valid", bus.rsp_valid, 8'h00);
        chk("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
        chk("rst_rsp_auto",  bus.rsp_auto,  8'h00);
        chk("rst_busy",      bus.busy,      8'h00);
        chk("rst_ready",     bus.req_ready, 8'h00);
        res = 1'b0;
        #1;
        chk("ready_after_res", bus.req_ready, 8'h01);

        // Write rs=2 wdata=FF: phi2_p two clks after handshake, phi2_n three later
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b0;
        bus.req_rs    = 4'h2;
        bus.req_wdata = 8'hFF;
        cyc(0, 0);
        bus.req_valid = 1'b0;
        chk("wr_busy",      bus.busy,      8'h01);
        chk("wr_ready_low", bus.req_ready, 8'h00);
        chk("wr_cs_wait0",  bus.cs_n,      8'h01);
        cyc(0, 0);
        chk("wr_cs_wait1",  bus.cs_n,      8'h01);
        cyc(1, 0);
        chk("wr_cs_low",    bus.cs_n,      8'h00);
        chk("wr_rw",        bus.rw,        8'h00);
        chk("wr_rs",        bus.rs,        8'h02);
        chk("wr_db_out",    bus.db_out,    8'hFF);
        cyc(0, 0);
        chk("wr_cs_hold0",  bus.cs_n,      8'h00);
        cyc(0, 0);
        chk("wr_cs_hold1",  bus.cs_n,      8'h00);
        chk("wr_no_rsp",    bus.rsp_valid, 8'h00);
        cyc(0, 1);
        chk("wr_cs_rise",   bus.cs_n,      8'h01);
        chk("wr_rw_idle",   bus.rw,        8'h01);
        chk("wr_db_hold",   bus.db_out,    8'hFF);
        chk("wr_cap_norsp", bus.rsp_valid, 8'h00);
        cyc(0, 0);
        chk("wr_rsp_valid", bus.rsp_valid, 8'h01);
        chk("wr_rdata_kept", bus.rsp_rdata, 8'h00);
        chk("wr_rsp_auto",  bus.rsp_auto,  8'h00);
        chk("wr_idle",      bus.busy,      8'h00);
        cyc(0, 0);
        chk("wr_rsp_pulse", bus.rsp_valid, 8'h00);
        chk("wr_cs_stays",  bus.cs_n,      8'h01);

        // Read rs=0; db_in is 33 in the phi2_n clk and 5A in the clk after
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b1;
        bus.req_rs    = 4'h0;
        cyc(0, 0);
        bus.req_valid = 1'b0;
        cyc(1, 0);
        chk("rd_cs_low", bus.cs_n, 8'h00);
        chk("rd_rw",     bus.rw,   8'h01);
        chk("rd_rs",     bus.rs,   8'h00);
        bus.db_in = 8'h33;
        cyc(0, 1);
        chk("rd_cs_rise", bus.cs_n, 8'h01);
        bus.db_in = 8'h5A;
        cyc(0, 0);
        bus.db_in = 8'h00;
        chk("rd_rsp_valid", bus.rsp_valid, 8'h01);
        chk("rd_rdata",     bus.rsp_rdata, 8'h5A);
        chk("rd_auto",      bus.rsp_auto,  8'h00);
        cyc(0, 0);
        chk("rd_rsp_pulse", bus.rsp_valid, 8'h00);
        chk("rd_rdata_hold", bus.rsp_rdata, 8'h5A);

        // Handshake coincident with phi2_p; coincident strobes act as phi2_p
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b0;
        bus.req_rs    = 4'h3;
        bus.req_wdata = 8'hA5;
        cyc(1, 0);
        bus.req_valid = 1'b0;
        chk("sync_cs_ignored", bus.cs_n, 8'h01);
        cyc(0, 0);
        cyc(0, 0);
        chk("sync_cs_wait", bus.cs_n, 8'h01);
        cyc(1, 0);
        chk("sync_cs_low", bus.cs_n,   8'h00);
        chk("sync_rs",     bus.rs,     8'h03);
        chk("sync_db",     bus.db_out, 8'hA5);
        cyc(1, 1);
        chk("both_strobes_hold", bus.cs_n, 8'h00);
        cyc(0, 1);
        chk("sync_cs_rise", bus.cs_n, 8'h01);
        cyc(0, 0);
        chk("sync_rsp", bus.rsp_valid, 8'h01);
        cyc(0, 0);

        // Reset pulse in ACCESS aborts the access
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b0;
        bus.req_rs    = 4'h5;
        bus.req_wdata = 8'h3C;
        cyc(0, 0);
        bus.req_valid = 1'b0;
        cyc(1, 0);
        chk("abort_cs_low", bus.cs_n, 8'h00);
        res = 1'b1;
        cyc(0, 0);
        chk("abort_cs_high", bus.cs_n,      8'h01);
        chk("abort_busy",    bus.busy,      8'h00);
        chk("abort_ready",   bus.req_ready, 8'h00);
        chk("abort_rs",      bus.rs,        8'h00);
        chk("abort_db",      bus.db_out,    8'h00);
        cyc(0, 1);
        chk("abort_no_rsp0", bus.rsp_valid, 8'h00);
        res = 1'b0;
        #1;
        chk("abort_ready_rel", bus.req_ready, 8'h01);
        cyc(0, 0);
        chk("abort_no_rsp1", bus.rsp_valid, 8'h00);
        chk("abort_cs_idle", bus.cs_n,      8'h01);
        cyc(0, 0);
        cyc(0, 0);

        // Back-to-back requests with req_valid held high
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b0;
        bus.req_rs    = 4'h1;
        bus.req_wdata = 8'h11;
        cyc(0, 0);
        bus.req_rs    = 4'h4;
        bus.req_wdata = 8'h22;
        cyc(1, 0);
        chk("b2b_a_cs",  bus.cs_n,   8'h00);
        chk("b2b_a_rs",  bus.rs,     8'h01);
        chk("b2b_a_db",  bus.db_out, 8'h11);
        cyc(0, 1);
        chk("b2b_a_cs_rise", bus.cs_n, 8'h01);
        cyc(0, 0);
        chk("b2b_a_rsp",   bus.rsp_valid, 8'h01);
        chk("b2b_ready",   bus.req_ready, 8'h01);
        chk("b2b_gap_cs",  bus.cs_n,      8'h01);
        cyc(0, 0);
        bus.req_valid = 1'b0;
        chk("b2b_b_busy",  bus.busy,      8'h01);
        chk("b2b_b_cs",    bus.cs_n,      8'h01);
        cyc(1, 0);
        chk("b2b_b_cs_low", bus.cs_n,   8'h00);
        chk("b2b_b_rs",     bus.rs,     8'h04);
        chk("b2b_b_db",     bus.db_out, 8'h22);
        cyc(0, 1);
        cyc(0, 0);
        chk("b2b_b_rsp", bus.rsp_valid, 8'h01);
        cyc(0, 0);

`ifdef CIA_IRQ_AUTOACK_EN
        // irq_n low while a host request is pending: ICR read goes first
        bus.irq_n = 1'b0;
        cyc(0, 0);
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b0;
        bus.req_rs    = 4'h6;
        bus.req_wdata = 8'h77;
        #1;
        chk("irq_ready_blocked", bus.req_ready, 8'h00);
        cyc(0, 0);
        chk("irq_busy", bus.busy, 8'h01);
        cyc(1, 0);
        chk("irq_cs_low", bus.cs_n, 8'h00);
        chk("irq_rw",     bus.rw,   8'h01);
        chk("irq_rs",     bus.rs,   8'h0D);
        cyc(0, 1);
        bus.db_in = 8'h81;
        cyc(0, 0);
        bus.db_in = 8'h00;
        chk("irq_rsp_valid", bus.rsp_valid, 8'h01);
        chk("irq_rsp_auto",  bus.rsp_auto,  8'h01);
        chk("irq_rdata",     bus.rsp_rdata, 8'h81);
        chk("irq_host_ready", bus.req_ready, 8'h01);
        cyc(0, 0);
        bus.req_valid = 1'b0;
        chk("irq_auto_pulse", bus.rsp_auto, 8'h00);
        cyc(1, 0);
        chk("host_cs_low", bus.cs_n,   8'h00);
        chk("host_rw",     bus.rw,     8'h00);
        chk("host_rs",     bus.rs,     8'h06);
        chk("host_db",     bus.db_out, 8'h77);
        cyc(0, 1);
        cyc(0, 0);
        chk("host_rsp",      bus.rsp_valid, 8'h01);
        chk("host_rsp_auto", bus.rsp_auto,  8'h00);
        cyc(0, 0);
        cyc(0, 0);
        cyc(0, 0);
        chk("irq_no_retrig", bus.busy,  8'h00);
        chk("irq_no_rsp",    bus.rsp_valid, 8'h00);
        // One-clk release of irq_n re-arms
        bus.irq_n = 1'b1;
        cyc(0, 0);
        bus.irq_n = 1'b0;
        cyc(0, 0);
        chk("rearm_idle",  bus.busy,      8'h00);
        chk("rearm_ready", bus.req_ready, 8'h00);
        cyc(0, 0);
        chk("rearm_busy", bus.busy, 8'h01);
        cyc(1, 0);
        chk("rearm_rs", bus.rs, 8'h0D);
        cyc(0, 1);
        bus.db_in = 8'h81;
        cyc(0, 0);
        bus.db_in = 8'h00;
        chk("rearm_auto", bus.rsp_auto, 8'h01);
        bus.irq_n = 1'b1;
        cyc(0, 0);
`else
        // irq_n has no effect in this build
        bus.irq_n = 1'b0;
        cyc(0, 0);
        cyc(0, 0);
        cyc(0, 0);
        chk("irq_ignored_busy",  bus.busy,      8'h00);
        chk("irq_ignored_ready", bus.req_ready, 8'h01);
        chk("irq_ignored_cs",    bus.cs_n,      8'h01);
        chk("irq_ignored_auto",  bus.rsp_auto,  8'h00);
        bus.irq_n = 1'b1;
        cyc(0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
